key_tx_scheduler: RTL

//  Collects single-cycle key pulses from NUM_KEYS single pulsers and queues one pending flag per key.

---
 rtl/key_tx_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/key_tx_scheduler.sv
// Round-robin key press queue feeding a UART TX over valid/ready, with an idle gap between bytes.
// Optional sticky drop flag: define KEY_TX_SCHEDULER_OVERFLOW_EN to add the overflow port.
module key_tx_scheduler #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter logic [7:0]  CODE_BASE  = 8'h30,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_p,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    output logic [NUM_KEYS-1:0] pending,
    output logic                busy
`ifdef KEY_TX_SCHEDULER_OVERFLOW_EN
    ,
    output logic                overflow
`endif
);

    localparam int unsigned IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q;

    logic                grant_found;
    logic [IW-1:0]       grant_idx;
    logic [IW-1:0]       search_idx;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] drop;

    // Search starts just after the last granted key and wraps, so every key gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int k = 1; k <= int'(NUM_KEYS); k++) begin
            search_idx = IW'((int'(rr_ptr_q) + k) % int'(NUM_KEYS));
            if (!grant_found && pending_q[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == StIdle && grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A new press beats a same-cycle grant, so that key is queued again.
    assign pending_d = key_p | (pending_q & ~grant);
    assign drop      = key_p & pending_q & ~grant;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gap_cnt_d  = gap_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    rr_ptr_d   = grant_idx;
                    tx_data_d  = CODE_BASE + 8'(grant_idx);
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = 16'(GAP_CYCLES - 1);
                        state_d   = StGap;
                    end
                end
            end
            StGap: begin
                tx_valid_d = 1'b0;
                if (gap_cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            rr_ptr_q   <= IW'(NUM_KEYS - 1);
            gap_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= (state_d != StIdle);
        end
    end

`ifdef KEY_TX_SCHEDULER_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (|drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_drop;
    assign unused_drop = |drop;
`endif

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign pending  = pending_q;
    assign busy     = busy_q;

endmodule
